fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: FETCH_UNIT

Interface
REQ-001 Parameter XLEN, default 32: PC/address width, 32 or 64.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC loaded on reset, zero-extended to XLEN.
REQ-003 Parameter BUF_DEPTH, default 2: instruction buffer entries, power of two, 1..8.
REQ-004 fetch_unit_clock_in  in  1  sole clock, rising edge.
REQ-005 fetch_unit_reset_in  in  1  asynchronous, active-low reset.
REQ-006 fetch_unit_mem_req_out  out  1  fetch request to instruction memory.
REQ-007 fetch_unit_mem_addr_out  out  XLEN  fetch address, valid while req high.
REQ-008 fetch_unit_mem_ack_in  in  1  response strobe, one cycle per request.
REQ-009 fetch_unit_mem_data_in  in  32  instruction word, valid with ack.
REQ-010 fetch_unit_redirect_in  in  1  branch/trap redirect strobe.
REQ-011 fetch_unit_redirect_pc_in  in  XLEN  redirect target.
REQ-012 fetch_unit_ins_valid_out  out  1  buffer head valid to decode.
REQ-013 fetch_unit_ins_ready_in  in  1  decode accepts head.
REQ-014 fetch_unit_ins_data_out  out  32  head instruction word.
REQ-015 fetch_unit_ins_pc_out  out  XLEN  PC of head instruction.

Function
REQ-016 Internal FSM SHALL have states IDLE, WAIT, DROP; one memory request outstanding at most.
REQ-017 IDLE: req low; go to WAIT next cycle when buffer occupancy < BUF_DEPTH and no redirect.
REQ-018 WAIT: req high, addr = PC; held stable until ack; ack may arrive the cycle after req rises or any later cycle.
REQ-019 WAIT with ack, no redirect: push {PC, data}, PC <= PC + 4 (modulo 2^XLEN); stay WAIT if occupancy after push/pop < BUF_DEPTH, else IDLE.
REQ-020 WAIT with redirect, no ack: flush buffer, PC <= target, go DROP.
REQ-021 WAIT with redirect and ack same cycle: discard response, flush buffer, PC <= target, go IDLE.
REQ-022 DROP: req low; on ack discard data, go IDLE; redirect in DROP updates PC, stays DROP.
REQ-023 IDLE with redirect: flush buffer, PC <= target, stay IDLE.
REQ-024 Redirect target bits [1:0] SHALL be forced to 0.
REQ-025 ack outside WAIT/DROP SHALL be ignored.
REQ-026 Buffer SHALL be first-word-fall-through FIFO: valid_out = not empty; pop on valid & ready.
REQ-027 Push and pop in the same cycle SHALL leave occupancy unchanged; push never occurs when full (slot reserved at request).
REQ-028 Redirect flush SHALL override a same-cycle pop; valid_out low the following cycle.
REQ-029 Fetch latency: ack in cycle N -> valid_out high in cycle N+1.

Reset
REQ-030 During reset: state IDLE, PC = RESET_VECTOR, buffer empty, req 0, addr RESET_VECTOR, valid 0, data 0, pc_out 0.
REQ-031 Reset asserted mid-request SHALL abandon it; a late ack after release, with state IDLE, is ignored.
REQ-032 First req SHALL rise in the second clock edge after reset deassertion.

Structure
REQ-033 Shared package CORE101_PKG SHALL hold FSM state encoding, INS_WIDTH = 32 and PC_STEP = 4.
REQ-034 Buffer SHALL be sub-module INS_BUFFER (parametrised width, depth, flush input, async active-low reset).

Verification
REQ-035 Reset release, RESET_VECTOR 0x100, ack 1 cycle after each req, ready high -> addr 0x100, 0x104, 0x108; pc_out follows.
REQ-036 ready low, BUF_DEPTH 2 -> two words buffered, req low; ready high -> req resumes at 0x108.
REQ-037 Redirect to 0x203 while WAIT, ack 3 cycles later with 0xDEADBEEF -> word dropped, next req addr 0x200, valid low meanwhile.
REQ-038 Redirect and ack same cycle -> no push; next req 1 cycle later at target.
REQ-039 XLEN 32, PC 0xFFFF_FFFC, ack -> next addr 0x0000_0000.
REQ-040 Reset pulse during WAIT, then stray ack -> buffer empty, first req at RESET_VECTOR.

Source files
------------

// File: rtl/core101_pkg.sv
// Shared core definitions: fetch FSM state encoding and instruction/PC constants.
package core101_pkg;

  localparam int unsigned INS_WIDTH = 32;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ins_buffer.sv
// First-word-fall-through instruction buffer with synchronous flush.
module ins_buffer #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  // Flush wins over both a same-cycle push and pop.
  assign do_push = push && !flush;
  assign do_pop  = pop && valid && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory requests feeding a FWFT buffer to decode.
module fetch_unit
  import core101_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH    = 2
) (
  input  logic                 fetch_unit_clock_in,
  input  logic                 fetch_unit_reset_in,
  output logic                 fetch_unit_mem_req_out,
  output logic [XLEN-1:0]      fetch_unit_mem_addr_out,
  input  logic                 fetch_unit_mem_ack_in,
  input  logic [INS_WIDTH-1:0] fetch_unit_mem_data_in,
  input  logic                 fetch_unit_redirect_in,
  input  logic [XLEN-1:0]      fetch_unit_redirect_pc_in,
  output logic                 fetch_unit_ins_valid_out,
  input  logic                 fetch_unit_ins_ready_in,
  output logic [INS_WIDTH-1:0] fetch_unit_ins_data_out,
  output logic [XLEN-1:0]      fetch_unit_ins_pc_out
);

  localparam int unsigned     ENTRY_W = XLEN + INS_WIDTH;
  localparam int unsigned     CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [XLEN-1:0] RV      = XLEN'(RESET_VECTOR);

  fetch_state_e      state;
  logic [XLEN-1:0]   pc;
  logic              run;
  logic [CNT_W-1:0]  count;
  logic [ENTRY_W-1:0] head;
  logic              pop_eff;
  logic              push;
  logic              fills_up;
  logic [XLEN-1:0]   target;

  assign target   = fetch_unit_redirect_pc_in & ~XLEN'(3);
  assign pop_eff  = fetch_unit_ins_valid_out && fetch_unit_ins_ready_in;
  assign push     = (state == ST_WAIT) && fetch_unit_mem_ack_in && !fetch_unit_redirect_in;
  // Occupancy after this push/pop would reach BUF_DEPTH, leaving no slot to reserve.
  assign fills_up = (count == CNT_W'(BUF_DEPTH - 1)) && !pop_eff;

  // run holds the FSM in IDLE for one edge after reset release, so the
  // first request rises on the second edge and stray acks are ignored.
  always_ff @(posedge fetch_unit_clock_in or negedge fetch_unit_reset_in) begin
    if (!fetch_unit_reset_in) begin
      state <= ST_IDLE;
      pc    <= RV;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (fetch_unit_redirect_in) pc <= target;
          else if (run && (count < CNT_W'(BUF_DEPTH))) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fetch_unit_redirect_in) begin
            pc    <= target;
            state <= fetch_unit_mem_ack_in ? ST_IDLE : ST_DROP;
          end else if (fetch_unit_mem_ack_in) begin
            pc <= pc + XLEN'(PC_STEP);
            if (fills_up) state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (fetch_unit_redirect_in) pc <= target;
          if (fetch_unit_mem_ack_in) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fetch_unit_mem_req_out  = (state == ST_WAIT);
  assign fetch_unit_mem_addr_out = pc;

  ins_buffer #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (fetch_unit_clock_in),
    .rst_n     (fetch_unit_reset_in),
    .flush     (fetch_unit_redirect_in),
    .push      (push),
    .push_data ({pc, fetch_unit_mem_data_in}),
    .pop       (fetch_unit_ins_ready_in),
    .valid     (fetch_unit_ins_valid_out),
    .head      (head),
    .count     (count)
  );

  assign fetch_unit_ins_pc_out   = head[ENTRY_W-1:INS_WIDTH];
  assign fetch_unit_ins_data_out = head[INS_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit (XLEN 32, RESET_VECTOR 0x100, BUF_DEPTH 2).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] mdata;
  logic        redir;
  logic [31:0] rpc;
  logic        valid;
  logic        ready;
  logic [31:0] idata;
  logic [31:0] ipc;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0100),
    .BUF_DEPTH    (2)
  ) dut (
    .fetch_unit_clock_in       (clk),
    .fetch_unit_reset_in       (rst_n),
    .fetch_unit_mem_req_out    (req),
    .fetch_unit_mem_addr_out   (addr),
    .fetch_unit_mem_ack_in     (ack),
    .fetch_unit_mem_data_in    (mdata),
    .fetch_unit_redirect_in    (redir),
    .fetch_unit_redirect_pc_in (rpc),
    .fetch_unit_ins_valid_out  (valid),
    .fetch_unit_ins_ready_in   (ready),
    .fetch_unit_ins_data_out   (idata),
    .fetch_unit_ins_pc_out     (ipc)
  );

  typedef struct {
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_data;
    logic [31:0] e_pc;
    logic        ack;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ed, input logic [31:0] ep,
                     input logic a, input logic [31:0] d, input logic r,
                     input logic [31:0] rp, input logic rdy);
    vec_t v;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_data = ed; v.e_pc = ep;
    v.ack = a; v.data = d; v.redir = r; v.rpc = rp; v.ready = rdy;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
  endtask

  task automatic chk_all(input int step, input logic er, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ed, input logic [31:0] ep);
    chk("req",   step, 32'(req),   32'(er));
    chk("addr",  step, addr,       ea);
    chk("valid", step, 32'(valid), 32'(ev));
    chk("data",  step, idata,      ed);
    chk("pc",    step, ipc,        ep);
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; mdata = '0; redir = 1'b0; rpc = '0; ready = 1'b0;

    //   exp: req addr          valid data          pc           | in: ack data          redir rpc           ready
    add(0, 32'h100,      0, 32'h0,         32'h0,        0, 32'h0,         0, 32'h0,         1);
    add(1, 32'h100,      0, 32'h0,         32'h0,        1, 32'h1111_0000, 0, 32'h0,         1);
    add(1, 32'h104,      1, 32'h1111_0000, 32'h100,      1, 32'h1111_0001, 0, 32'h0,         1);
    add(1, 32'h108,      1, 32'h1111_0001, 32'h104,      1, 32'h1111_0002, 0, 32'h0,         1);
    add(1, 32'h10C,      1, 32'h1111_0002, 32'h108,      1, 32'h1111_0003, 0, 32'h0,         0);
    add(0, 32'h110,      1, 32'h1111_0002, 32'h108,      0, 32'h0,         0, 32'h0,         0);
    add(0, 32'h110,      1, 32'h1111_0002, 32'h108,      0, 32'h0,         0, 32'h0,         1);
    add(0, 32'h110,      1, 32'h1111_0003, 32'h10C,      0, 32'h0,         0, 32'h0,         0);
    add(1, 32'h110,      1, 32'h1111_0003, 32'h10C,      0, 32'h0,         0, 32'h0,         0);
    add(1, 32'h110,      1, 32'h1111_0003, 32'h10C,      0, 32'h0,         1, 32'h203,       0);
    add(0, 32'h200,      0, 32'h0,         32'h0,        0, 32'h0,         0, 32'h0,         0);
    add(0, 32'h200,      0, 32'h0,         32'h0,        0, 32'h0,         0, 32'h0,         0);
    add(0, 32'h200,      0, 32'h0,         32'h0,        1, 32'hDEAD_BEEF, 0, 32'h0,         1);
    add(0, 32'h200,      0, 32'h0,         32'h0,        0, 32'h0,         0, 32'h0,         1);
    add(1, 32'h200,      0, 32'h0,         32'h0,        1, 32'hB0B0_B0B0, 1, 32'hFFFF_FFFE, 1);
    add(0, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,        0, 32'h0,         0, 32'h0,         1);
    add(1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,        1, 32'hB1B1_B1B1, 0, 32'h0,         1);
    add(1, 32'h0,        1, 32'hB1B1_B1B1, 32'hFFFF_FFFC, 0, 32'h0,        0, 32'h0,         1);
    add(1, 32'h0,        0, 32'h0,         32'h0,        1, 32'hB2B2_B2B2, 0, 32'h0,         0);
    add(1, 32'h4,        1, 32'hB2B2_B2B2, 32'h0,        0, 32'h0,         1, 32'h300,       1);
    add(0, 32'h300,      0, 32'h0,         32'h0,        0, 32'h0,         1, 32'h401,       1);
    add(0, 32'h400,      0, 32'h0,         32'h0,        1, 32'hC0C0_C0C0, 0, 32'h0,         1);
    add(0, 32'h400,      0, 32'h0,         32'h0,        1, 32'hC1C1_C1C1, 0, 32'h0,         1);
    add(1, 32'h400,      0, 32'h0,         32'h0,        0, 32'h0,         0, 32'h0,         1);

    repeat (2) @(negedge clk);
    chk_all(0, 0, 32'h100, 0, 32'h0, 32'h0);
    rst_n = 1'b1;
    ready = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      chk_all(i + 1, tv[i].e_req, tv[i].e_addr, tv[i].e_valid, tv[i].e_data, tv[i].e_pc);
      ack = tv[i].ack; mdata = tv[i].data; redir = tv[i].redir;
      rpc = tv[i].rpc; ready = tv[i].ready;
    end

    // Reset pulse while a request is outstanding, then a stray ack after release.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all(100, 0, 32'h100, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ack = 1'b1; mdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk_all(101, 0, 32'h100, 0, 32'h0, 32'h0);
    ack = 1'b0; mdata = '0;
    @(negedge clk);
    chk_all(102, 1, 32'h100, 0, 32'h0, 32'h0);
    ack = 1'b1; mdata = 32'hD0D0_D0D0;
    @(negedge clk);
    chk_all(103, 1, 32'h104, 1, 32'hD0D0_D0D0, 32'h100);
    ack = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
